data_mem_ctrl: RTL and testbench

//  Initiator/sequencer for the 16x4 data memory. The memory has a registered read (R_data valid
//  the cycle after D_rd) and ignores cycles with D_rd&&D_wr. This block accepts one op per

---
 rtl/data_mem_ctrl_pkg.sv | 40 ++++
 rtl/data_mem_ctrl_if.sv | 36 +++
 rtl/data_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// ============================================================================
// data_mem_ctrl_pkg : shared types and defaults for the data memory sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package data_mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_CAP  = 3'd3,
    ST_WR_A = 3'd4,
    ST_WR_B = 3'd5,
    ST_RESP = 3'd6
  } state_e;

  // Plain-vector encodings of state_e for the state register.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_WR_A = 3'd4;
  localparam logic [2:0] S_WR_B = 3'd5;
  localparam logic [2:0] S_RESP = 3'd6;

endpackage

`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
// ============================================================================
// data_mem_ctrl_if : request/response handshake between requester and sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface data_mem_ctrl_if
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  op_e               req_op;
  logic [ADDR_W-1:0] req_addr_a;
  logic [ADDR_W-1:0] req_addr_b;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              busy;

  modport master (
    output req_valid, req_op, req_addr_a, req_addr_b, req_wdata,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr_a, req_addr_b, req_wdata,
    output req_ready, resp_valid, resp_data, busy
  );

endinterface

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// data_mem_ctrl : sequences LOAD/STORE/COPY/SWAP onto a registered-read memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  wire logic              clk,
  input  wire logic              reset,
  data_mem_ctrl_if.slave         req_if,
  output logic [ADDR_W-1:0]      D_addr,
  output logic                   D_rd,
  output logic                   D_wr,
  output logic [DATA_W-1:0]      W_data,
  input  wire logic [DATA_W-1:0] R_data
);

  logic [2:0]        state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] tmp_a_q, tmp_a_d;
  logic [DATA_W-1:0] tmp_b_q, tmp_b_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    wdata_d     = wdata_q;
    tmp_a_d     = tmp_a_q;
    tmp_b_d     = tmp_b_q;
    resp_data_d = resp_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_if.req_valid) begin
          op_d    = req_if.req_op;
          a_d     = req_if.req_addr_a;
          b_d     = req_if.req_addr_b;
          wdata_d = req_if.req_wdata;
          state_d = (req_if.req_op == OP_STORE) ? S_WR_A : S_RD_A;
        end
      end
      S_RD_A: state_d = (op_q == OP_SWAP) ? S_RD_B : S_CAP;
      S_RD_B: begin
        // R_data now holds the word read from A during RD_A.
        tmp_a_d = R_data;
        state_d = S_CAP;
      end
      S_CAP: begin
        if (op_q == OP_SWAP) begin
          tmp_b_d = R_data;
          state_d = S_WR_A;
        end else begin
          tmp_a_d = R_data;
          if (op_q == OP_LOAD) begin
            resp_data_d = R_data;
            state_d     = S_RESP;
          end else begin
            state_d = S_WR_B;
          end
        end
      end
      S_WR_A: begin
        if (op_q == OP_SWAP) begin
          state_d = S_WR_B;
        end else begin
          resp_data_d = wdata_q;
          state_d     = S_RESP;
        end
      end
      S_WR_B: begin
        resp_data_d = tmp_a_q;
        state_d     = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_LOAD;
      a_q          <= '0;
      b_q          <= '0;
      wdata_q      <= '0;
      tmp_a_q      <= '0;
      tmp_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      wdata_q      <= wdata_d;
      tmp_a_q      <= tmp_a_d;
      tmp_b_q      <= tmp_b_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Strobes decode from the current state only, so a reset edge never cuts one short.
  always_comb begin
    D_rd   = 1'b0;
    D_wr   = 1'b0;
    D_addr = '0;
    W_data = '0;
    case (state_q)
      S_RD_A: begin
        D_rd   = 1'b1;
        D_addr = a_q;
      end
      S_RD_B: begin
        D_rd   = 1'b1;
        D_addr = b_q;
      end
      S_WR_A: begin
        D_wr   = 1'b1;
        D_addr = a_q;
        W_data = (op_q == OP_STORE) ? wdata_q : tmp_b_q;
      end
      S_WR_B: begin
        D_wr   = 1'b1;
        D_addr = b_q;
        W_data = tmp_a_q;
      end
      default: begin
        D_rd   = 1'b0;
        D_wr   = 1'b0;
      end
    endcase
  end

  assign req_if.req_ready  = (state_q == S_IDLE);
  assign req_if.busy       = (state_q != S_IDLE);
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_data  = resp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// tb_data_mem_ctrl : directed + random ops against a 16x4 memory and array model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] D_addr;
  logic       D_rd, D_wr;
  logic [3:0] W_data;
  logic [3:0] R_data = 4'h0;

  data_mem_ctrl_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  data_mem_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .req_if (bus),
    .D_addr (D_addr),
    .D_rd   (D_rd),
    .D_wr   (D_wr),
    .W_data (W_data),
    .R_data (R_data)
  );

  always #5 clk = ~clk;

  // Memory under control: registered read, collision cycles ignored.
  logic [3:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 4'(i);
  always @(posedge clk) begin
    if (D_rd && !D_wr) R_data <= mem[D_addr];
    else if (D_wr && !D_rd) mem[D_addr] <= W_data;
  end

  int rd_cnt = 0, wr_cnt = 0, clash_cnt = 0, resp_cnt = 0;
  always @(negedge clk) begin
    if (D_rd) rd_cnt++;
    if (D_wr) wr_cnt++;
    if (D_rd && D_wr) clash_cnt++;
    if (bus.resp_valid) resp_cnt++;
  end

  int n_checks = 0, n_pass = 0;
  logic [3:0] ref_mem [16];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_lat(input op_e op);
    case (op)
      OP_LOAD:  return 3;
      OP_STORE: return 2;
      OP_COPY:  return 4;
      default:  return 6;
    endcase
  endfunction

  function automatic int exp_rd(input op_e op);
    return (op == OP_STORE) ? 0 : (op == OP_SWAP) ? 2 : 1;
  endfunction

  function automatic int exp_wr(input op_e op);
    return (op == OP_LOAD) ? 0 : (op == OP_SWAP) ? 2 : 1;
  endfunction

  // Applies the operation to the model and returns the expected response word.
  function automatic logic [3:0] model_op(input op_e op, input logic [3:0] a, b, wd);
    logic [3:0] t;
    t = ref_mem[a];
    case (op)
      OP_LOAD:  return t;
      OP_STORE: begin ref_mem[a] = wd; return wd; end
      OP_COPY:  begin ref_mem[b] = t; return t; end
      default:  begin ref_mem[a] = ref_mem[b]; ref_mem[b] = t; return t; end
    endcase
  endfunction

  task automatic drive_req(input op_e op, input logic [3:0] a, b, wd);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_addr_a = a;
    bus.req_addr_b = b;
    bus.req_wdata  = wd;
  endtask

  task automatic do_op(input op_e op, input logic [3:0] a, b, wd, input string tag);
    int n, rd0, wr0, busy_n;
    bit seen;
    logic [3:0] exp;
    exp = model_op(op, a, b, wd);
    @(negedge clk); #1;
    check({tag, ".ready"}, int'(bus.req_ready), 1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    drive_req(op, a, b, wd);
    n = 0; seen = 0; busy_n = 0;
    while (!seen && n < 20) begin
      @(negedge clk); #1;
      n++;
      bus.req_valid = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.resp_valid) seen = 1;
    end
    check({tag, ".latency"}, n, exp_lat(op));
    check({tag, ".data"}, int'(bus.resp_data), int'(exp));
    check({tag, ".rd_strobes"}, rd_cnt - rd0, exp_rd(op));
    check({tag, ".wr_strobes"}, wr_cnt - wr0, exp_wr(op));
    check({tag, ".busy_cycles"}, busy_n, exp_lat(op));
    @(negedge clk); #1;
    check({tag, ".pulse_once"}, int'(bus.resp_valid), 0);
    check({tag, ".data_hold"}, int'(bus.resp_data), int'(exp));
  endtask

  initial begin
    int n, busy_n, t1, t2, r0;
    logic [3:0] e1, e2;
    for (int i = 0; i < 16; i++) ref_mem[i] = 4'(i);
    bus.req_valid = 1'b0; bus.req_op = OP_LOAD;
    bus.req_addr_a = '0; bus.req_addr_b = '0; bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.resp_valid", int'(bus.resp_valid), 0);
    check("rst.resp_data", int'(bus.resp_data), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.ready", int'(bus.req_ready), 1);
    check("rst.strobes", int'({D_rd, D_wr}), 0);
    reset = 1'b0;

    do_op(OP_LOAD, 4'd5, 4'd0, 4'd0, "load5");
    do_op(OP_STORE, 4'd3, 4'd0, 4'hA, "store3");
    do_op(OP_LOAD, 4'd3, 4'd0, 4'd0, "load3");
    do_op(OP_COPY, 4'd9, 4'd2, 4'd0, "copy9_2");
    do_op(OP_LOAD, 4'd2, 4'd0, 4'd0, "load2");
    do_op(OP_LOAD, 4'd9, 4'd0, 4'd0, "load9");
    do_op(OP_SWAP, 4'd1, 4'd14, 4'd0, "swap1_14");
    do_op(OP_LOAD, 4'd1, 4'd0, 4'd0, "load1");
    do_op(OP_LOAD, 4'd14, 4'd0, 4'd0, "load14");
    do_op(OP_SWAP, 4'd7, 4'd7, 4'd0, "swap7_7");
    do_op(OP_LOAD, 4'd7, 4'd0, 4'd0, "load7");

    // Request held through a SWAP; the queued LOAD waits for IDLE.
    e1 = model_op(OP_SWAP, 4'd10, 4'd11, 4'd0);
    e2 = model_op(OP_LOAD, 4'd0, 4'd0, 4'd0);
    @(negedge clk); #1;
    drive_req(OP_SWAP, 4'd10, 4'd11, 4'd0);
    @(negedge clk); #1;
    drive_req(OP_LOAD, 4'd0, 4'd0, 4'd0);
    n = 1; busy_n = 1; t1 = 0; t2 = 0;
    while (t2 == 0 && n < 20) begin
      if (n == 7) check("hold.ready_after_resp", int'(bus.req_ready), 1);
      if (n == 8) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        if (t1 == 0) t1 = n;
        else t2 = n;
        check($sformatf("hold.data%0d", (t2 == 0) ? 1 : 2), int'(bus.resp_data),
              int'((t2 == 0) ? e1 : e2));
      end
      if (t1 == 0 && t2 == 0 && n > 1 && bus.busy) busy_n++;
      if (t2 == 0) begin @(negedge clk); #1; n++; end
    end
    bus.req_valid = 1'b0;
    check("hold.swap_latency", t1, 6);
    check("hold.load_latency", t2, 10);
    check("hold.swap_busy", busy_n, 5);

    // Reset during the WR_A cycle of a SWAP.
    @(negedge clk); #1;
    drive_req(OP_SWAP, 4'd4, 4'd6, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      bus.req_valid = 1'b0;
    end
    check("rstmid.wr_a_strobe", int'(D_wr), 1);
    check("rstmid.wr_a_addr", int'(D_addr), 4);
    reset = 1'b1;
    r0 = resp_cnt;
    @(negedge clk); #1;
    check("rstmid.ready", int'(bus.req_ready), 1);
    check("rstmid.busy", int'(bus.busy), 0);
    check("rstmid.strobes", int'({D_rd, D_wr, D_addr, W_data}), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rstmid.no_resp", resp_cnt - r0, 0);
    ref_mem[4] = ref_mem[6];
    do_op(OP_LOAD, 4'd4, 4'd0, 4'd0, "rstmid.load4");
    do_op(OP_LOAD, 4'd6, 4'd0, 4'd0, "rstmid.load6");

    for (int i = 0; i < 40; i++) begin
      op_e op;
      op = op_e'($urandom_range(0, 3));
      do_op(op, 4'($urandom), 4'($urandom), 4'($urandom), $sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 16; i++)
      do_op(OP_LOAD, 4'(i), 4'd0, 4'd0, $sformatf("sweep%0d", i));

    check("no_rd_wr_clash", clash_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
